// File: rtl/mf_ctrl_pkg.sv
// Shared state encoding, counter widths and helpers for the frame controller.
package mf_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int PIX_W  = 16;
  localparam int LINE_W = 16;
  localparam int TMO_W  = 20;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mf_edge_reg.sv
// One-cycle source stream register with sync edge detection and a gate that
// zeroes the forwarded stream whenever the frame is not being admitted.
module mf_edge_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fwd,
  input  logic          src_vsync,
  input  logic          src_hsync,
  input  logic [DW-1:0] src_din,
  input  logic          flt_out_vsync,
  output logic          flt_vsync,
  output logic          flt_hsync,
  output logic [DW-1:0] flt_din,
  output logic          vs_rise,
  output logic          vs_fall,
  output logic          hs_fall,
  output logic          fo_fall
);

  logic          vs_q;
  logic          hs_q;
  logic          fo_q;
  logic [DW-1:0] din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q  <= 1'b0;
      hs_q  <= 1'b0;
      fo_q  <= 1'b0;
      din_q <= '0;
    end else begin
      vs_q  <= src_vsync;
      hs_q  <= src_hsync;
      fo_q  <= flt_out_vsync;
      din_q <= src_din;
    end
  end

  assign vs_rise = src_vsync & ~vs_q;
  assign vs_fall = ~src_vsync & vs_q;
  assign hs_fall = ~src_hsync & hs_q;
  assign fo_fall = ~flt_out_vsync & fo_q;

  assign flt_vsync = fwd & vs_q;
  assign flt_hsync = fwd & hs_q;
  assign flt_din   = fwd ? din_q : '0;

endmodule

// File: rtl/mf_frame_ctrl.sv
// Frame admission controller in front of the mean filter.
// state | meaning
// IDLE  | stopped, waiting for cfg_start
// ARM   | waiting for a fresh src_vsync rising edge
// RUN   | forwarding the frame, checking line length and line count
// DRAIN | waiting for the filter output frame to end (or timeout)
module mf_frame_ctrl
  import mf_ctrl_pkg::*;
#(
  parameter int DW      = 8,
  parameter int IW      = 640,
  parameter int IH      = 480,
  parameter int TMO_CLK = 1048575
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_stop,
  input  logic          cfg_cont,
  input  logic          cfg_bypass,
  input  logic          err_clr,
  input  logic          src_vsync,
  input  logic          src_hsync,
  input  logic [DW-1:0] src_din,
  output logic          flt_vsync,
  output logic          flt_hsync,
  output logic [DW-1:0] flt_din,
  input  logic          flt_out_vsync,
  output logic          byp_sel,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          err_len,
  output logic          err_lines,
  output logic          err_tmo
);

  state_t              state, state_nxt;
  logic                vs_rise, vs_fall, hs_fall, fo_fall;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt, lines_eff;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                stop_pend, done_ok, tmo_hit, len_bad, lines_bad;

  mf_edge_reg #(.DW(DW)) u_edge (
    .clk           (clk),
    .rst_n         (rst_n),
    .fwd           (state == ST_RUN),
    .src_vsync     (src_vsync),
    .src_hsync     (src_hsync),
    .src_din       (src_din),
    .flt_out_vsync (flt_out_vsync),
    .flt_vsync     (flt_vsync),
    .flt_hsync     (flt_hsync),
    .flt_din       (flt_din),
    .vs_rise       (vs_rise),
    .vs_fall       (vs_fall),
    .hs_fall       (hs_fall),
    .fo_fall       (fo_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_ok   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE:  if (cfg_start && !cfg_stop) state_nxt = ST_ARM;
      ST_ARM: begin
        if (cfg_stop)     state_nxt = ST_IDLE;
        else if (vs_rise) state_nxt = ST_RUN;
      end
      ST_RUN:   if (vs_fall) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        // Completion beats the timeout when both land on the same cycle.
        if (byp_sel || fo_fall) begin
          done_ok   = 1'b1;
          state_nxt = (cfg_cont && !stop_pend && !cfg_stop) ? ST_ARM : ST_IDLE;
        end else if (tmo_cnt == '0) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // A line ending on the same cycle as vsync still belongs to this frame.
  assign lines_eff = hs_fall ? sat_inc16(line_cnt) : line_cnt;
  assign len_bad   = (state == ST_RUN) && hs_fall && (pix_cnt != PIX_W'(IW));
  assign lines_bad = (state == ST_RUN) && vs_fall && (lines_eff != LINE_W'(IH));
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt    <= '0;
      line_cnt   <= '0;
      tmo_cnt    <= '0;
      stop_pend  <= 1'b0;
      byp_sel    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_len    <= 1'b0;
      err_lines  <= 1'b0;
      err_tmo    <= 1'b0;
    end else begin
      frame_done <= done_ok;
      if (done_ok) frame_cnt <= frame_cnt + 16'd1;

      if (state == ST_ARM && state_nxt == ST_RUN) byp_sel <= cfg_bypass;

      if (state_nxt == ST_IDLE)
        stop_pend <= 1'b0;
      else if (cfg_stop && (state == ST_RUN || state == ST_DRAIN))
        stop_pend <= 1'b1;

      if (state != ST_RUN) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
      end else begin
        if (hs_fall)        pix_cnt <= '0;
        else if (src_hsync) pix_cnt <= sat_inc16(pix_cnt);
        if (hs_fall)        line_cnt <= sat_inc16(line_cnt);
      end

      if (state == ST_RUN && vs_fall)
        tmo_cnt <= TMO_W'(TMO_CLK - 1);
      else if (state == ST_DRAIN && tmo_cnt != '0)
        tmo_cnt <= tmo_cnt - 1'b1;

      err_len   <= len_bad   | (err_len   & ~err_clr);
      err_lines <= lines_bad | (err_lines & ~err_clr);
      err_tmo   <= tmo_hit   | (err_tmo   & ~err_clr);
    end
  end

endmodule

// File: tb/tb_mf_frame_ctrl.sv
// Directed bench for mf_frame_ctrl with an 8x4 frame and a 16-clock drain timeout.
module tb_mf_frame_ctrl;

  localparam int IW_T = 8;
  localparam int IH_T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_start = 1'b0, cfg_stop = 1'b0, cfg_cont = 1'b0, cfg_bypass = 1'b0, err_clr = 1'b0;
  logic       src_vsync = 1'b0, src_hsync = 1'b0;
  logic [7:0] src_din = 8'd0;
  logic       flt_out_vsync = 1'b0;
  logic       flt_vsync, flt_hsync, byp_sel, busy, frame_done, err_len, err_lines, err_tmo;
  logic [7:0] flt_din;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mf_frame_ctrl #(.DW(8), .IW(IW_T), .IH(IH_T), .TMO_CLK(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_start     (cfg_start),
    .cfg_stop      (cfg_stop),
    .cfg_cont      (cfg_cont),
    .cfg_bypass    (cfg_bypass),
    .err_clr       (err_clr),
    .src_vsync     (src_vsync),
    .src_hsync     (src_hsync),
    .src_din       (src_din),
    .flt_vsync     (flt_vsync),
    .flt_hsync     (flt_hsync),
    .flt_din       (flt_din),
    .flt_out_vsync (flt_out_vsync),
    .byp_sel       (byp_sel),
    .busy          (busy),
    .frame_done    (frame_done),
    .frame_cnt     (frame_cnt),
    .err_len       (err_len),
    .err_lines     (err_lines),
    .err_tmo       (err_tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {cfg_start, cfg_stop, cfg_cont, cfg_bypass, err_clr} = '0;
    {src_vsync, src_hsync, flt_out_vsync} = '0;
    src_din = 8'd0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drives one source cycle and checks the forwarded stream one clock later.
  task automatic drive(input logic v, input logic h, input logic [7:0] d, input bit fwd);
    src_vsync = v;
    src_hsync = h;
    src_din   = d;
    tick();
    chk("flt_vsync", {31'd0, flt_vsync}, fwd ? {31'd0, v} : 32'd0);
    chk("flt_hsync", {31'd0, flt_hsync}, fwd ? {31'd0, h} : 32'd0);
    chk("flt_din",   {24'd0, flt_din},   fwd ? {24'd0, d} : 32'd0);
  endtask

  // evt_kind 1 pulses cfg_stop, 2 toggles cfg_bypass, at the start of evt_line.
  task automatic run_frame(input int lines, input int short_ln, input bit fwd,
                           input int evt_line, input int evt_kind);
    flt_out_vsync = 1'b1;
    drive(1'b1, 1'b0, 8'd0, fwd);
    for (int l = 0; l < lines; l++) begin
      int n;
      n = (l == short_ln) ? 7 : IW_T;
      for (int p = 0; p < n; p++) begin
        if (l == evt_line && p == 0) begin
          if (evt_kind == 1)      cfg_stop = 1'b1;
          else if (evt_kind == 2) cfg_bypass = ~cfg_bypass;
        end
        drive(1'b1, 1'b1, 8'(16 * l + p + 1), fwd);
        cfg_stop = 1'b0;
      end
      drive(1'b1, 1'b0, 8'd0, fwd);
      drive(1'b1, 1'b0, 8'd0, fwd);
    end
    drive(1'b0, 1'b0, 8'd0, fwd);
  endtask

  task automatic finish_drain(input int exp_cnt, input bit exp_busy);
    tick();
    chk("done_early", {31'd0, frame_done}, 32'd0);
    tick();
    chk("done_early", {31'd0, frame_done}, 32'd0);
    flt_out_vsync = 1'b0;
    tick();
    chk("frame_done", {31'd0, frame_done}, 32'd1);
    chk("frame_cnt",  {16'd0, frame_cnt}, 32'(exp_cnt));
    chk("busy_after", {31'd0, busy}, {31'd0, exp_busy});
    tick();
    chk("done_pulse", {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, frame_done}, 32'd0);
    chk("rst_cnt",   {16'd0, frame_cnt}, 32'd0);
    chk("rst_errs",  {29'd0, err_len, err_lines, err_tmo}, 32'd0);
    chk("rst_byp",   {31'd0, byp_sel}, 32'd0);
    chk("rst_flt",   {22'd0, flt_vsync, flt_hsync, flt_din}, 32'd0);

    // Start+stop together in IDLE stays idle; stop in ARM returns to IDLE
    cfg_start = 1'b1; cfg_stop = 1'b1;
    tick();
    chk("start_stop_idle", {31'd0, busy}, 32'd0);
    cfg_stop = 1'b0;
    tick();
    chk("arm_busy", {31'd0, busy}, 32'd1);
    cfg_start = 1'b0; cfg_stop = 1'b1;
    tick();
    chk("arm_stop", {31'd0, busy}, 32'd0);
    cfg_stop = 1'b0;

    // Clean frame
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(4, -1, 1'b1, -1, 0);
    chk("drain_busy", {31'd0, busy}, 32'd1);
    finish_drain(1, 1'b0);
    chk("clean_errs", {29'd0, err_len, err_lines, err_tmo}, 32'd0);

    // Start while a frame is already in progress
    do_reset();
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b1, 1'b1, 8'h51, 1'b0);
    drive(1'b1, 1'b1, 8'h52, 1'b0);
    cfg_start = 1'b1;
    drive(1'b1, 1'b1, 8'h53, 1'b0);
    cfg_start = 1'b0;
    drive(1'b1, 1'b1, 8'h54, 1'b0);
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    chk("midframe_armed", {31'd0, busy}, 32'd1);
    run_frame(4, -1, 1'b1, -1, 0);
    finish_drain(1, 1'b0);

    // Short line and short frame, then clear; set beats clear
    do_reset();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(3, 1, 1'b1, -1, 0);
    chk("err_len_set",   {31'd0, err_len}, 32'd1);
    chk("err_lines_set", {31'd0, err_lines}, 32'd1);
    finish_drain(1, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_len_clr",   {31'd0, err_len}, 32'd0);
    chk("err_lines_clr", {31'd0, err_lines}, 32'd0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    err_clr = 1'b1;
    run_frame(3, -1, 1'b1, -1, 0);
    chk("set_wins_lines", {31'd0, err_lines}, 32'd1);
    chk("full_lines_ok",  {31'd0, err_len}, 32'd0);
    tick();
    chk("clr_after_set",  {31'd0, err_lines}, 32'd0);
    err_clr = 1'b0;
    finish_drain(2, 1'b0);

    // Continuous mode with stop during frame 2
    do_reset();
    cfg_cont = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(4, -1, 1'b1, -1, 0);
    finish_drain(1, 1'b1);
    run_frame(4, -1, 1'b1, 2, 1);
    finish_drain(2, 1'b0);
    run_frame(4, -1, 1'b0, -1, 0);
    tick();
    chk("cont_cnt",  {16'd0, frame_cnt}, 32'd2);
    chk("cont_idle", {31'd0, busy}, 32'd0);
    cfg_cont = 1'b0;
    flt_out_vsync = 1'b0;

    // Drain timeout
    do_reset();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(4, -1, 1'b1, -1, 0);
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("tmo_early", {31'd0, err_tmo}, 32'd0);
    end
    chk("tmo_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("tmo_set",  {31'd0, err_tmo}, 32'd1);
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    chk("tmo_cnt",  {16'd0, frame_cnt}, 32'd0);
    chk("tmo_done", {31'd0, frame_done}, 32'd0);
    flt_out_vsync = 1'b0;
    tick();
    chk("tmo_late_done", {31'd0, frame_done}, 32'd0);

    // Bypass latched at frame start; bypass drain completes without filter
    do_reset();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(4, -1, 1'b1, 1, 2);
    chk("byp_hold0", {31'd0, byp_sel}, 32'd0);
    finish_drain(1, 1'b0);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    run_frame(4, -1, 1'b1, 2, 2);
    chk("byp_hold1", {31'd0, byp_sel}, 32'd1);
    tick();
    chk("byp_done", {31'd0, frame_done}, 32'd1);
    chk("byp_cnt",  {16'd0, frame_cnt}, 32'd2);
    chk("byp_idle", {31'd0, busy}, 32'd0);
    flt_out_vsync = 1'b0;

    // Asynchronous reset in RUN
    cfg_bypass = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    drive(1'b1, 1'b0, 8'd0, 1'b1);
    drive(1'b1, 1'b1, 8'h21, 1'b1);
    drive(1'b1, 1'b1, 8'h22, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_flt",  {22'd0, flt_vsync, flt_hsync, flt_din}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_byp",  {31'd0, byp_sel}, 32'd0);
    chk("arst_cnt",  {16'd0, frame_cnt}, 32'd0);
    cfg_bypass = 1'b0;
    tick();
    rst_n = 1'b1;
    cfg_start = 1'b1;
    drive(1'b1, 1'b1, 8'h23, 1'b0);
    cfg_start = 1'b0;
    drive(1'b1, 1'b1, 8'h24, 1'b0);
    drive(1'b1, 1'b0, 8'd0, 1'b0);
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    chk("post_rst_armed", {31'd0, busy}, 32'd1);
    run_frame(4, -1, 1'b1, -1, 0);
    finish_drain(1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mf_frame_ctrl.md
MF_FRAME_CTRL -- requirements
Module: mf_frame_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, pixel data width.
REQ-002 SHALL have parameter IW, default 640, expected pixels per line.
REQ-003 SHALL have parameter IH, default 480, expected lines per frame.
REQ-004 SHALL have parameter TMO_CLK, default 1048575, drain timeout in clocks (20-bit counter).
REQ-005 SHALL have ports: clk in 1 clock; rst_n in 1 async active-low reset.
REQ-006 SHALL have ports: cfg_start in 1 start pulse; cfg_stop in 1 stop pulse; cfg_cont in 1 continuous mode; cfg_bypass in 1 bypass request; err_clr in 1 clear sticky errors.
REQ-007 SHALL have ports: src_vsync in 1; src_hsync in 1; src_din in DW (source stream).
REQ-008 SHALL have ports: flt_vsync out 1; flt_hsync out 1; flt_din out DW (to mean filter input); flt_out_vsync in 1 (mean filter output vsync).
REQ-009 SHALL have ports: byp_sel out 1; busy out 1; frame_done out 1; frame_cnt out 16; err_len out 1; err_lines out 1; err_tmo out 1.

Function
REQ-010 SHALL implement FSM IDLE, ARM, RUN, DRAIN; encoding from package.
REQ-011 IDLE: cfg_start -> ARM; all other inputs ignored.
REQ-012 ARM: rising edge of src_vsync -> RUN; frame is never admitted mid-frame (src_vsync already high at entry is skipped until it falls and rises again).
REQ-013 On ARM->RUN SHALL latch cfg_bypass into byp_sel; byp_sel SHALL hold for the whole frame, including DRAIN.
REQ-014 RUN: flt_vsync/flt_hsync/flt_din SHALL equal src_vsync/src_hsync/src_din delayed exactly 1 clock; outside RUN (and the one trailing cycle) flt_vsync=flt_hsync=0, flt_din=0.
REQ-015 RUN: count hsync-high cycles per line; on hsync falling edge, count!=IW sets err_len (sticky).
REQ-016 RUN: count hsync falling edges; on src_vsync falling edge, count!=IH sets err_lines (sticky); then -> DRAIN.
REQ-017 DRAIN: falling edge of flt_out_vsync -> 1-cycle frame_done pulse, frame_cnt+1 (wraps 0xFFFF->0); next state ARM if cfg_cont=1 and no stop pending, else IDLE.
REQ-018 DRAIN: if byp_sel=1, flt_out_vsync is not waited for; completion occurs the cycle after entry.
REQ-019 DRAIN: timeout counter reaching TMO_CLK-1 sets err_tmo (sticky), no frame_done, no count increment, -> IDLE.
REQ-020 cfg_stop in ARM -> IDLE next cycle; in RUN/DRAIN sets stop-pending, frame completes normally, then IDLE; stop-pending cleared on entry to IDLE.
REQ-021 cfg_start outside IDLE SHALL be ignored; cfg_start and cfg_stop together in IDLE -> stay IDLE.
REQ-022 busy SHALL be 1 in ARM, RUN, DRAIN.
REQ-023 err_clr SHALL clear all sticky errors; a same-cycle set wins over clear.
REQ-024 Pixel and line counters SHALL saturate at all-ones, never wrap.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, all outputs 0, counters 0, stop-pending 0.
REQ-026 Reset mid-frame SHALL drop flt_vsync/flt_hsync immediately; after release, the next frame is admitted only via cfg_start and a fresh src_vsync rising edge.

Structure
REQ-027 State encoding, counter widths (pixel 16, line 16, timeout 20) SHALL live in shared package mf_ctrl_pkg.
REQ-028 Edge detection and 1-cycle stream register SHALL be a sub-module mf_edge_reg; FSM and counters SHALL remain in mf_frame_ctrl.

Verification
REQ-029 IW=8,IH=4: cfg_start, one clean frame -> flt_* mirrors src_* 1 clock later, frame_done 1 cycle after flt_out_vsync falls, frame_cnt=1, no errors.
REQ-030 cfg_start while src_vsync high mid-frame -> flt_vsync stays 0 until next rising edge; that frame counted, frame_cnt=1.
REQ-031 Line of 7 pixels then frame of 3 lines -> err_len=1, err_lines=1; err_clr -> both 0.
REQ-032 cfg_cont=1, 3 frames, cfg_stop during frame 2 -> frame_cnt=2, IDLE, frame 3 not forwarded.
REQ-033 TMO_CLK=16, flt_out_vsync held high -> err_tmo=1 16 cycles into DRAIN, IDLE, frame_cnt unchanged.
REQ-034 cfg_bypass toggled mid-frame -> byp_sel unchanged until next frame start; rst_n low in RUN -> all outputs 0 same cycle.
